// File: rtl/mac_pkg.sv
// Shared types and elaboration helpers for the multi-lane MAC accumulator.
package mac_pkg;

   // Pass sequencing: idle, accepting products, waiting for the last result to drain.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } mac_state_t;

   // Result width that holds the sum of k full-width products without wrap.
   function automatic int res_w(input int dw, input int k);
      return 2 * dw + $clog2(k);
   endfunction

   // Counter/address width that never collapses to zero bits.
   function automatic int cnt_w(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   // LSB position of a lane inside a packed multi-lane bus.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/mac_accum_multilane_if.sv
// Product-side and C-side handshake bundle of the multi-lane MAC accumulator.
interface mac_accum_multilane_if
   import mac_pkg::*;
#(
   parameter int M     = 4,
   parameter int K     = 4,
   parameter int N     = 4,
   parameter int LANES = 2,
   parameter int DW    = 32,
   parameter int RW    = res_w(DW, K)
) ();

   logic                     start;
   logic                     prod_valid;
   logic                     prod_ready;
   logic [LANES*2*DW-1:0]    prod_data;
   logic                     c_valid;
   logic                     c_ready;
   logic [LANES*RW-1:0]      c_data;
   logic [cnt_w(M)-1:0]      c_row_addr;
   logic [cnt_w(N)-1:0]      c_col_addr;
   logic                     busy;
   logic                     mac_done;

   // The accumulator block itself.
   modport slave (
      input  start, prod_valid, prod_data, c_ready,
      output prod_ready, c_valid, c_data, c_row_addr, c_col_addr, busy, mac_done
   );

   // The controller / multiplier / C writer side.
   modport master (
      output start, prod_valid, prod_data, c_ready,
      input  prod_ready, c_valid, c_data, c_row_addr, c_col_addr, busy, mac_done
   );

endinterface

// File: rtl/mac_lane_accum.sv
// One accumulation lane: widens a product, adds it to the running sum and
// exposes acc+ext so the final term can be written out without an extra cycle.
module mac_lane_accum #(
   parameter int PW = 64,
   parameter int RW = 66
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          signed_mode,
   input  logic          add_en,
   input  logic          clr,
   input  logic          fin,
   input  logic [PW-1:0] prod,
   output logic [RW-1:0] sum
);

   logic [RW-1:0] acc;
   logic [RW-1:0] ext;

   // Widen the product to the result width, sign- or zero-filling the top bits.
   always_comb begin
      ext = {{(RW-PW){1'b0}}, prod};
      if (signed_mode) begin
         ext = {{(RW-PW){prod[PW-1]}}, prod};
      end
   end

   assign sum = acc + ext;

   // Running sum: restarts on a new pass and after the last term of each dot product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= fin ? '0 : sum;
      end
   end

endmodule

// File: rtl/mac_accum_multilane.sv
// Multi-lane stop-accumulate MAC stage: sums K products per lane, walks rows
// and column groups with internal counters and hands finished groups to the
// C writer through a one-entry output register.
module mac_accum_multilane
   import mac_pkg::*;
#(
   parameter int M                        = 4,
   parameter int K                        = 4,
   parameter int N                        = 4,
   parameter int LANES                    = 2,
   parameter int DATA_WIDTH_INIT_MATRIX   = 32,
   parameter int DATA_WIDTH_RESULT_MATRIX = res_w(DATA_WIDTH_INIT_MATRIX, K),
   parameter bit SIGNED                   = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   mac_accum_multilane_if.slave bus
);

   localparam int DW     = DATA_WIDTH_INIT_MATRIX;
   localparam int RW     = DATA_WIDTH_RESULT_MATRIX;
   localparam int PW     = 2 * DW;
   localparam int GROUPS = N / LANES;
   localparam int KW     = cnt_w(K);
   localparam int GW     = cnt_w(GROUPS);
   localparam int RAW    = cnt_w(M);
   localparam int CAW    = cnt_w(N);

   mac_state_t           state;
   mac_state_t           state_next;

   logic [KW-1:0]        k_cnt;
   logic [GW-1:0]        grp_cnt;
   logic [RAW-1:0]       row_cnt;

   logic                 c_valid;
   logic [LANES*RW-1:0]  c_data;
   logic [RAW-1:0]       c_row;
   logic [CAW-1:0]       c_col;
   logic                 mac_done;

   logic [LANES*RW-1:0]  sum_bus;
   logic [CAW-1:0]       col_base;
   logic                 prod_ready;
   logic                 busy;
   logic                 launch;
   logic                 drain_done;
   logic                 accept;
   logic                 k_last;
   logic                 grp_last;
   logic                 row_last;
   logic                 final_term;

   assign k_last     = (k_cnt == KW'(K - 1));
   assign grp_last   = (grp_cnt == GW'(GROUPS - 1));
   assign row_last   = (row_cnt == RAW'(M - 1));
   assign final_term = k_last && grp_last && row_last;
   assign accept     = bus.prod_valid && prod_ready;
   assign col_base   = CAW'(grp_cnt) * CAW'(LANES);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane_accum #(
         .PW (PW),
         .RW (RW)
      ) u_lane (
         .clk         (clk),
         .reset       (reset),
         .signed_mode (SIGNED),
         .add_en      (accept),
         .clr         (launch),
         .fin         (k_last),
         .prod        (bus.prod_data[lane_lsb(gi, PW) +: PW]),
         .sum         (sum_bus[lane_lsb(gi, RW) +: RW])
      );
   end

   // Next state and handshake outputs. The last term of a group may only enter
   // when the output register is free or is being drained this same cycle.
   always_comb begin
      state_next = state;
      prod_ready = 1'b0;
      busy       = 1'b0;
      launch     = 1'b0;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            launch = bus.start;
            if (bus.start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy       = 1'b1;
            prod_ready = !k_last || !c_valid || bus.c_ready;
            if (bus.prod_valid && prod_ready && final_term) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (c_valid && bus.c_ready) begin
               drain_done = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Position counters: cleared on a new pass, advanced per accepted term.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_cnt   <= '0;
         grp_cnt <= '0;
         row_cnt <= '0;
      end else if (launch) begin
         k_cnt   <= '0;
         grp_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (k_last) begin
            k_cnt <= '0;
            if (grp_last) begin
               grp_cnt <= '0;
               row_cnt <= row_last ? '0 : row_cnt + RAW'(1);
            end else begin
               grp_cnt <= grp_cnt + GW'(1);
            end
         end else begin
            k_cnt <= k_cnt + KW'(1);
         end
      end
   end

   // Output register: loads on the last term, holds under backpressure,
   // empties on handshake unless reloaded in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_valid <= 1'b0;
         c_data  <= '0;
         c_row   <= '0;
         c_col   <= '0;
      end else if (accept && k_last) begin
         c_valid <= 1'b1;
         c_data  <= sum_bus;
         c_row   <= row_cnt;
         c_col   <= col_base;
      end else if (c_valid && bus.c_ready) begin
         c_valid <= 1'b0;
      end
   end

   // Completion pulse, one cycle after the final group leaves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mac_done <= 1'b0;
      end else begin
         mac_done <= drain_done;
      end
   end

   assign bus.prod_ready = prod_ready;
   assign bus.busy       = busy;
   assign bus.c_valid    = c_valid;
   assign bus.c_data     = c_data;
   assign bus.c_row_addr = c_row;
   assign bus.c_col_addr = c_col;
   assign bus.mac_done   = mac_done;

endmodule

// File: tb/tb_mac_accum_multilane.sv
// Bench for mac_accum_multilane: an unsigned 2x2x2 instance and a signed
// 2x4x4 instance, driven one at a time through shared stimulus signals.
module tb_mac_accum_multilane;
   import mac_pkg::*;

   localparam int DW = 8;
   localparam int PW = 16;
   localparam int AM = 2, AK = 2, AN = 2, AL = 2;
   localparam int ARW = res_w(DW, AK);
   localparam int BM = 2, BK = 4, BN = 4, BL = 2;
   localparam int BRW = res_w(DW, BK);
   localparam int PASS_LIMIT = 400;

   typedef struct {
      int          row;
      int          col;
      logic [63:0] data;
   } grp_t;

   typedef struct {
      string       name;
      logic [15:0] p [2][2][2];   // [row][k][lane] products
      logic [16:0] c [2][2];      // [row][lane] expected results
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int sel = 0;

   logic        t_start = 1'b0;
   logic        t_pvalid = 1'b0;
   logic        t_cready = 1'b0;
   logic [63:0] t_pdata = '0;

   logic        m_pready, m_cvalid, m_busy, m_done;
   logic [63:0] m_cdata;
   int          m_row, m_col;

   grp_t        exp_q[$];
   grp_t        got_q[$];
   logic [63:0] prod_q[$];
   logic [15:0] pv [2][2][4][2];   // [row][group][k][lane]
   vec_t        tbl [3];

   mac_accum_multilane_if #(.M(AM), .K(AK), .N(AN), .LANES(AL), .DW(DW)) a_if ();
   mac_accum_multilane_if #(.M(BM), .K(BK), .N(BN), .LANES(BL), .DW(DW)) b_if ();

   mac_accum_multilane #(
      .M(AM), .K(AK), .N(AN), .LANES(AL), .DATA_WIDTH_INIT_MATRIX(DW), .SIGNED(1'b0)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   mac_accum_multilane #(
      .M(BM), .K(BK), .N(BN), .LANES(BL), .DATA_WIDTH_INIT_MATRIX(DW), .SIGNED(1'b1)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   assign a_if.start      = (sel == 0) && t_start;
   assign a_if.prod_valid = (sel == 0) && t_pvalid;
   assign a_if.c_ready    = (sel == 0) && t_cready;
   assign a_if.prod_data  = t_pdata[AL*PW-1:0];
   assign b_if.start      = (sel == 1) && t_start;
   assign b_if.prod_valid = (sel == 1) && t_pvalid;
   assign b_if.c_ready    = (sel == 1) && t_cready;
   assign b_if.prod_data  = t_pdata[BL*PW-1:0];

   always_comb begin
      if (sel == 0) begin
         m_pready = a_if.prod_ready;
         m_cvalid = a_if.c_valid;
         m_busy   = a_if.busy;
         m_done   = a_if.mac_done;
         m_cdata  = 64'(a_if.c_data);
         m_row    = int'(a_if.c_row_addr);
         m_col    = int'(a_if.c_col_addr);
      end else begin
         m_pready = b_if.prod_ready;
         m_cvalid = b_if.c_valid;
         m_busy   = b_if.busy;
         m_done   = b_if.mac_done;
         m_cdata  = 64'(b_if.c_data);
         m_row    = int'(b_if.c_row_addr);
         m_col    = int'(b_if.c_col_addr);
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   // Output register must hold still while stalled by the C writer.
   logic        st_prev = 1'b0;
   logic [63:0] st_data = '0;
   int          st_row = 0, st_col = 0;
   always @(negedge clk) begin
      if (st_prev && m_cvalid) begin
         check("c_data_hold", m_cdata, st_data);
         check("c_addr_hold", {m_row[15:0], m_col[15:0]}, {st_row[15:0], st_col[15:0]});
      end
      st_prev = m_cvalid && !t_cready && !reset;
      st_data = m_cdata;
      st_row  = m_row;
      st_col  = m_col;
   end

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, m_busy, 0);
      check({tag, "_c_valid"}, m_cvalid, 0);
      check({tag, "_mac_done"}, m_done, 0);
      check({tag, "_prod_ready"}, m_pready, 0);
      check({tag, "_c_data"}, m_cdata, 0);
      check({tag, "_c_addr"}, {m_row[15:0], m_col[15:0]}, 0);
   endtask

   // Flattens pv into the product stream; optionally derives expected groups
   // by summing the widened products of each dot product modulo 2^RW.
   task automatic load_pass(input bit use_model);
      int mm, kk, ngrp, ll, rw;
      longint sum;
      logic [63:0] word, data, mask;
      mm   = (sel == 1) ? BM : AM;
      kk   = (sel == 1) ? BK : AK;
      ll   = (sel == 1) ? BL : AL;
      ngrp = (sel == 1) ? BN / BL : AN / AL;
      rw   = (sel == 1) ? BRW : ARW;
      mask = (64'd1 << rw) - 64'd1;
      prod_q.delete();
      if (use_model) exp_q.delete();
      for (int r = 0; r < mm; r++) begin
         for (int g = 0; g < ngrp; g++) begin
            for (int k = 0; k < kk; k++) begin
               word = '0;
               for (int ln = 0; ln < ll; ln++) word |= 64'(pv[r][g][k][ln]) << (ln * PW);
               prod_q.push_back(word);
            end
            if (use_model) begin
               data = '0;
               for (int ln = 0; ln < ll; ln++) begin
                  sum = 0;
                  for (int k = 0; k < kk; k++)
                     sum += (sel == 1) ? longint'($signed(pv[r][g][k][ln])) : longint'(pv[r][g][k][ln]);
                  data |= (64'(sum) & mask) << (ln * rw);
               end
               exp_q.push_back('{r, g * ll, data});
            end
         end
      end
   endtask

   task automatic fill_random();
      for (int r = 0; r < 2; r++)
         for (int g = 0; g < 2; g++)
            for (int k = 0; k < 4; k++)
               for (int ln = 0; ln < 2; ln++)
                  pv[r][g][k][ln] = 16'($urandom);
   endtask

   // Runs one pass from start to mac_done and compares every handshaken group.
   task automatic run_pass(input int rdy_pct, input int val_pct, input bit poke_start);
      int kk, tot, acc_n, cyc, last_hs, done_cyc, done_cnt, nchk;
      logic exp_ready;
      kk = (sel == 1) ? BK : AK;
      tot = prod_q.size();
      acc_n = 0; last_hs = -1; done_cyc = -1; done_cnt = 0;
      got_q.delete();
      @(posedge clk); #1; t_start = 1'b1;
      @(posedge clk); #1; t_start = 1'b0;
      for (cyc = 0; cyc < PASS_LIMIT; cyc++) begin
         if (poke_start) t_start = (cyc == 2);
         t_pvalid = (prod_q.size() > 0) && ($urandom_range(0, 99) < val_pct);
         t_pdata  = t_pvalid ? prod_q[0] : {$urandom, $urandom};
         t_cready = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         if (cyc == 0) check("busy_after_start", m_busy, 1);
         exp_ready = (acc_n < tot) && ((acc_n % kk) != kk - 1 || !m_cvalid || t_cready);
         check($sformatf("prod_ready_cyc%0d", cyc), m_pready, exp_ready);
         if (t_pvalid && m_pready) begin
            void'(prod_q.pop_front());
            acc_n++;
         end
         if (m_cvalid && t_cready) begin
            got_q.push_back('{m_row, m_col, m_cdata});
            last_hs = cyc;
         end
         if (m_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (!m_busy) break;
         @(posedge clk); #1;
      end
      t_start = 1'b0; t_pvalid = 1'b0; t_cready = 1'b0;
      n_cmp++;
      if (cyc >= PASS_LIMIT) begin
         n_bad++;
         $display("FAIL pass_timeout: busy=%0d after %0d cycles, required 0", m_busy, cyc);
      end
      @(posedge clk); #1; @(negedge clk);
      check("mac_done_width", m_done, 0);
      check("mac_done_count", done_cnt, 1);
      check("mac_done_timing", done_cyc, last_hs + 1);
      check("terms_consumed", acc_n, tot);
      check("group_count", got_q.size(), exp_q.size());
      nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nchk; i++) begin
         $display("dut%0d group %0d: row %0d col %0d data %0h (expect row %0d col %0d data %0h)",
                  sel, i, got_q[i].row, got_q[i].col, got_q[i].data,
                  exp_q[i].row, exp_q[i].col, exp_q[i].data);
         check($sformatf("grp%0d_row", i), got_q[i].row, exp_q[i].row);
         check($sformatf("grp%0d_col", i), got_q[i].col, exp_q[i].col);
         check($sformatf("grp%0d_data", i), got_q[i].data, exp_q[i].data);
      end
   endtask

   task automatic load_table(input int i);
      sel = 0;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 2; k++)
            for (int ln = 0; ln < 2; ln++)
               pv[r][0][k][ln] = tbl[i].p[r][k][ln];
      load_pass(1'b0);
      exp_q.delete();
      for (int r = 0; r < 2; r++)
         exp_q.push_back('{r, 0, (64'(tbl[i].c[r][1]) << ARW) | 64'(tbl[i].c[r][0])});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] g;

      tbl[0].name = "matrix_2x2";
      tbl[0].p = '{'{'{16'd5, 16'd6}, '{16'd14, 16'd16}}, '{'{16'd15, 16'd18}, '{16'd28, 16'd32}}};
      tbl[0].c = '{'{17'd19, 17'd22}, '{17'd43, 17'd50}};
      tbl[1].name = "max_unsigned";
      tbl[1].p = '{default: 16'hFFFF};
      tbl[1].c = '{default: 17'h1FFFE};
      tbl[2].name = "carry_edges";
      tbl[2].p = '{'{'{16'h0000, 16'h0001}, '{16'h0000, 16'hFFFF}}, '{'{16'h8000, 16'h1234}, '{16'h8000, 16'h0000}}};
      tbl[2].c = '{'{17'h00000, 17'h10000}, '{17'h10000, 17'h01234}};

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      sel = 0; #1; check_idle("reset_a");
      sel = 1; #1; check_idle("reset_b");
      sel = 0;

      // prod_valid while idle must not wake the block.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         t_pvalid = 1'b1; t_pdata = {$urandom, $urandom}; t_cready = 1'b1;
         @(negedge clk);
         check_idle($sformatf("idle_pvalid%0d", i));
      end
      @(posedge clk); #1; t_pvalid = 1'b0; t_cready = 1'b0;

      // Directed vectors, back-to-back with no backpressure.
      for (int i = 0; i < 3; i++) begin
         $display("vector %s", tbl[i].name);
         load_table(i);
         run_pass(100, 100, 1'b0);
      end

      // Signed lane: -3 + 5 - 7 + 1 = -4.
      sel = 1;
      fill_random();
      pv[0][0][0][0] = 16'hFFFD;
      pv[0][0][1][0] = 16'h0005;
      pv[0][0][2][0] = 16'hFFF9;
      pv[0][0][3][0] = 16'h0001;
      load_pass(1'b1);
      run_pass(100, 100, 1'b0);
      g = (got_q.size() > 0) ? got_q[0].data : '1;
      check("signed_minus4", g & 64'h3FFFF, 64'h3FFFC);

      // Heavy C-side backpressure on the unsigned instance.
      sel = 0;
      fill_random();
      load_pass(1'b1);
      run_pass(15, 100, 1'b0);

      // Randomized passes, some with a start pulse while busy.
      for (int i = 0; i < 8; i++) begin
         sel = i % 2;
         fill_random();
         load_pass(1'b1);
         run_pass(20 + 10 * i, 40 + 8 * i, (i == 2) || (i == 3));
      end

      // Reset in the middle of row 1 with a result still held.
      load_table(0);
      @(posedge clk); #1; t_start = 1'b1;
      @(posedge clk); #1; t_start = 1'b0; t_cready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         t_pvalid = 1'b1; t_pdata = prod_q[0];
         @(negedge clk);
         check($sformatf("rst_seq_ready%0d", i), m_pready, 1);
         if (m_pready) void'(prod_q.pop_front());
         @(posedge clk); #1;
      end
      t_pvalid = 1'b0;
      @(negedge clk);
      check("cvalid_before_reset", m_cvalid, 1);
      check("busy_before_reset", m_busy, 1);
      #2 reset = 1'b1;
      #1;
      check("reset_mid_c_valid", m_cvalid, 0);
      check("reset_mid_busy", m_busy, 0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_idle("after_mid_reset");
      load_table(0);
      run_pass(100, 100, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_accum_multilane.md
Name: mac_accum_multilane

Overview:
Parametrised successor to the single-lane stop-accumulate MAC stage. It sits between the multiplier stage and matrix C memory. It accumulates LANES independent product streams over K terms and tracks row, column and k position with its own counters, so no address inputs are needed. It supports signed or unsigned products and uses a valid/ready handshake on both sides, with a one-entry output register that absorbs C-side backpressure.

Parameters:
M, 4, rows of A and C (must be >= 2)
K, 4, inner dimension and terms per dot product (must be >= 2)
N, 4, columns of B and C (must be >= 2; N % LANES == 0)
LANES, 2, parallel output columns computed per dot-product pass
DATA_WIDTH_INIT_MATRIX, 32, A/B element width (DW)
DATA_WIDTH_RESULT_MATRIX, 2*DW+$clog2(K), C element width (RW)
SIGNED, 0, 1 = products are two's complement and are sign-extended; 0 = products are zero-extended

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse that begins a new matrix pass; ignored while busy=1
prod_valid  in  1  product lanes are valid
prod_ready  out  1  block accepts the product lanes this cycle
prod_data  in  LANES*2*DW  lane i occupies bits [i*2DW +: 2DW]
c_valid  out  1  output register holds a completed result group
c_ready  in  1  C writer accepts the group
c_data  out  LANES*RW  lane i result occupies bits [i*RW +: RW]
c_row_addr  out  $clog2(M)  row of the result group
c_col_addr  out  $clog2(N)  first column of the group; lane i writes column c_col_addr+i
busy  out  1  a pass is in progress
mac_done  out  1  one-cycle pulse after the final group is handshaken

Behaviour:
- Reset values:
  - busy=0, mac_done=0, c_valid=0
  - c_data=0, c_row_addr=0, c_col_addr=0
  - all accumulators and counters = 0
- start while busy=0:
  - next cycle busy=1
  - k_cnt=0, grp_cnt=0, row_cnt=0, accumulators cleared
- Accept condition: accept = prod_valid && prod_ready.
- prod_ready = busy && (k_cnt != K-1 || !c_valid || c_ready). A final term may be accepted in the same cycle the output register drains.
- Per lane i, the extended product ext_i is the 2DW-bit lane widened to RW bits: sign-extended when SIGNED=1, zero-extended otherwise.
- On accept with k_cnt < K-1: acc_i <= acc_i + ext_i; k_cnt++.
- On accept with k_cnt == K-1:
  - c_data lane i <= acc_i + ext_i
  - c_row_addr <= row_cnt; c_col_addr <= grp_cnt*LANES
  - c_valid <= 1; acc_i <= 0; k_cnt <= 0
  - advance grp_cnt; on the last group, wrap grp_cnt to 0 and increment row_cnt
  - latency: the result is visible the cycle after the final term is accepted
- Arithmetic: RW bits, modulo 2^RW. The width guarantees no overflow for K terms.
- Output register:
  - c_valid clears on c_valid && c_ready unless it is reloaded in the same cycle
  - c_data and addresses hold stable while c_valid=1 and c_ready=0
- Completion:
  - when the group for row M-1, last column group, is handshaken on C, busy <= 0 and mac_done=1 for exactly one cycle
  - prod_ready=0 from the cycle after the last term is accepted
- FSM states:
  - IDLE -> RUN on start
  - RUN -> DRAIN when the final term is accepted
  - DRAIN -> IDLE on the final C handshake, pulsing mac_done
- prod_valid while busy=0 is ignored and has no effect on state.
- Reset asserted mid-pass returns the block to IDLE immediately. Any pending c_valid is dropped.

Decomposition:
- Shared package mac_pkg:
  - result-width function res_w(DW,K) = 2*DW+$clog2(K)
  - FSM state enum {IDLE, RUN, DRAIN}
  - lane-slice helper functions
- Sub-module mac_lane_accum, one per lane, instantiated via generate:
  - inputs: extend mode, add enable, clear, final
  - holds acc_i and produces acc_i+ext_i
- The top level holds the counters, FSM and output register.

Test Plan:
- Unsigned, M=K=N=2, LANES=2; A=[[1,2],[3,4]], B=[[5,6],[7,8]], products fed back-to-back with c_ready=1:
  - c groups (row,col)=(0,0){19,22} then (1,0){43,50}
  - mac_done pulses one cycle after the second group
- SIGNED=1, K=4, one lane fed products -3, 5, -7, 1 (2DW-bit two's complement) -> result -4 in RW bits, i.e. all ones except bit pattern ...FFFC.
- Backpressure: hold c_ready=0 while the next group's K-1 terms arrive:
  - prod_ready drops only at k_cnt==K-1
  - c_data stays stable
  - releasing c_ready accepts the stalled term in the same cycle
- Max values, SIGNED=0: every product = 2^(2DW)-1 for K terms -> result K*(2^(2DW)-1) exactly, with no wrap.
- start pulsed while busy and prod_valid pulsed while idle -> no state change, no c_valid.
- Reset asserted mid-row with c_valid=1 -> c_valid=0, busy=0 next edge; a following start yields correct results from row 0.
